// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO of 2**ADDR_SPACE words with a registered read port.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo #(
    parameter int DATA_SIZE  = 64,
    parameter int ADDR_SPACE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [DATA_SIZE-1:0] wr_data,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    output logic                 overflow,
    output logic                 underflow,
`endif
    output logic                 full
);
    localparam int DEPTH = 2 ** ADDR_SPACE;
    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [ADDR_SPACE:0] wr_ptr, rd_ptr;
    logic wr_ok, rd_ok;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[ADDR_SPACE-1:0] == rd_ptr[ADDR_SPACE-1:0]) && (wr_ptr[ADDR_SPACE] != rd_ptr[ADDR_SPACE]);
    assign rd_ok = rd_en && !empty;
    // a read in the same cycle frees the slot, so a full FIFO still accepts the write
    assign wr_ok = wr_en && (!full || rd_ok);
    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr[ADDR_SPACE-1:0]] <= wr_data;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_data <= mem[rd_ptr[ADDR_SPACE-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !wr_ok) overflow <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
        end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: queue-model checked bench for sync_fifo with directed vectors.
module tb_sync_fifo;
    localparam int DEPTH = 16;
    logic clk = 1'b0, rst = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [63:0] wr_data = '0, rd_data;
    logic empty, full;
    int checks = 0, failures = 0;
    logic [63:0] q[$];
    logic [63:0] m_rd;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow, underflow, m_ovf, m_unf;
`endif
    sync_fifo #(.DATA_SIZE(64), .ADDR_SPACE(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data),
        .rd_data(rd_data), .empty(empty),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .overflow(overflow), .underflow(underflow),
`endif
        .full(full));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask
    // reference: a plain queue with FIFO acceptance rules
    always @(posedge clk or posedge rst)
        if (rst) begin
            q.delete();
            m_rd = '0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            m_ovf = 1'b0;
            m_unf = 1'b0;
`endif
        end else begin
            automatic bit r = rd_en && q.size() > 0;
            automatic bit w = wr_en && (q.size() < DEPTH || r);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            if (wr_en && !w) m_ovf = 1'b1;
            if (rd_en && q.size() == 0) m_unf = 1'b1;
`endif
            if (r) m_rd = q.pop_front();
            if (w) q.push_back(wr_data);
        end
    always @(negedge clk) begin
        chk("model_empty", {63'd0, empty}, {63'd0, q.size() == 0});
        chk("model_full", {63'd0, full}, {63'd0, q.size() == DEPTH});
        chk("model_rd_data", rd_data, m_rd);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("model_overflow", {63'd0, overflow}, {63'd0, m_ovf});
        chk("model_underflow", {63'd0, underflow}, {63'd0, m_unf});
`endif
    end
    task automatic cycle(input logic w, input logic r, input logic [63:0] d);
        wr_en = w;
        rd_en = r;
        wr_data = d;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask
    initial begin
        logic [63:0] exp_rd;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_empty", {63'd0, empty}, 64'd1);
        chk("reset_full", {63'd0, full}, 64'd0);
        chk("reset_rd_data", rd_data, 64'd0);
        cycle(1, 0, 64'hA5A5A5A5A5A5A5A5);
        chk("single_not_empty", {63'd0, empty}, 64'd0);
        cycle(0, 1, '0);
        chk("single_rd_data", rd_data, 64'hA5A5A5A5A5A5A5A5);
        chk("single_empty", {63'd0, empty}, 64'd1);
        for (int i = 0; i < 16; i++) cycle(1, 0, 64'(i));
        chk("fill_full", {63'd0, full}, 64'd1);
        cycle(1, 0, 64'hDEADBEEFDEADBEEF);
        chk("drop_full", {63'd0, full}, 64'd1);
        chk("drop_rd_data", rd_data, 64'hA5A5A5A5A5A5A5A5);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("drop_overflow", {63'd0, overflow}, 64'd1);
`endif
        cycle(1, 1, 64'h1234567890ABCDEF);
        chk("simul_full_rd", rd_data, 64'd0);
        chk("simul_full_flag", {63'd0, full}, 64'd1);
        for (int i = 1; i < 16; i++) begin
            cycle(0, 1, '0);
            chk("drain_rd", rd_data, 64'(i));
        end
        cycle(0, 1, '0);
        chk("drain_last", rd_data, 64'h1234567890ABCDEF);
        chk("drain_empty", {63'd0, empty}, 64'd1);
        cycle(0, 1, '0);
        chk("underrun_rd_data", rd_data, 64'h1234567890ABCDEF);
        chk("underrun_empty", {63'd0, empty}, 64'd1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("underrun_flag", {63'd0, underflow}, 64'd1);
`endif
        cycle(1, 1, 64'h77);
        chk("simul_empty_rd", rd_data, 64'h1234567890ABCDEF);
        chk("simul_empty_flag", {63'd0, empty}, 64'd0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 64'hB0 + 64'(i));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_empty", {63'd0, empty}, 64'd1);
        chk("async_rst_rd_data", rd_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_empty", {63'd0, empty}, 64'd1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("post_rst_overflow", {63'd0, overflow}, 64'd0);
`endif
        for (int i = 0; i < 14; i++) cycle(1, 0, 64'hC000 + 64'(i));
        exp_rd = 64'hC000;
        for (int i = 14; i < 40; i++) begin
            cycle(1, 1, 64'hC000 + 64'(i));
            chk("wrap_rd", rd_data, exp_rd);
            exp_rd++;
        end
        chk("wrap_not_full", {63'd0, full}, 64'd0);
        for (int i = 0; i < 14; i++) begin
            cycle(0, 1, '0);
            chk("wrap_drain", rd_data, exp_rd);
            exp_rd++;
        end
        chk("wrap_empty", {63'd0, empty}, 64'd1);
        chk("wrap_last", rd_data, 64'hC027);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
